// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter for the shared instruction/data memory port.
// One transaction in flight; reads return through a per-port data register.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_rvalid,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t            state_q, state_d;
    logic              sel_q, sel_d;
    logic              last_q, last_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign sel_we    = sel_q ? m1_we    : m0_we;
    assign sel_addr  = sel_q ? m1_addr  : m0_addr;
    assign sel_wdata = sel_q ? m1_wdata : m0_wdata;

    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= 1'b0;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        m0_rvalid = 1'b0;
        m1_rvalid = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state_q)
            IDLE: begin
                // On a tie the port that did not win last time goes next
                if (m0_req || m1_req) begin
                    sel_d   = (m0_req && m1_req) ? ~last_q : m1_req;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = sel_we;
                mem_addr  = sel_addr;
                mem_wdata = sel_wdata;
                m0_gnt    = ~sel_q;
                m1_gnt    = sel_q;
                last_d    = sel_q;
                if (sel_we) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = LAT_M1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (sel_q) begin
                        rdata1_d = mem_rdata;
                    end else begin
                        rdata0_d = mem_rdata;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                m0_rvalid = ~sel_q;
                m1_rvalid = sel_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, reset-abort sequence and
// randomized traffic on three latencies checked against a transaction model.
module tb_mem_port_arbiter;

    localparam int NI = 3;

    typedef struct packed {
        logic        g0, g1, v0, v1, en, we;
        logic [31:0] addr, wd, rd0, rd1;
    } ob_t;

    typedef struct {
        logic        r0, w0;
        logic [31:0] a0, d0;
        logic        r1, w1;
        logic [31:0] a1, d1, mrd;
        ob_t         exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        r0[NI], w0[NI], r1[NI], w1[NI];
    logic [31:0] a0[NI], d0[NI], a1[NI], d1[NI], mrd[NI];
    logic        g0[NI], g1[NI], v0[NI], v1[NI], en[NI], we[NI];
    logic [31:0] ad[NI], wd[NI], rd0[NI], rd1[NI];

    int total = 0;
    int bad   = 0;
    int k     = 0;

    for (genvar i = 0; i < NI; i++) begin : g_dut
        mem_port_arbiter #(
            .ADDR_W (32),
            .DATA_W (32),
            .MEM_LAT(i == 0 ? 2 : (i == 1 ? 1 : 15))
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .m0_req   (r0[i]),
            .m0_we    (w0[i]),
            .m0_addr  (a0[i]),
            .m0_wdata (d0[i]),
            .m0_gnt   (g0[i]),
            .m0_rdata (rd0[i]),
            .m0_rvalid(v0[i]),
            .m1_req   (r1[i]),
            .m1_we    (w1[i]),
            .m1_addr  (a1[i]),
            .m1_wdata (d1[i]),
            .m1_gnt   (g1[i]),
            .m1_rdata (rd1[i]),
            .m1_rvalid(v1[i]),
            .mem_en   (en[i]),
            .mem_we   (we[i]),
            .mem_addr (ad[i]),
            .mem_wdata(wd[i]),
            .mem_rdata(mrd[i])
        );
    end

    function automatic int lat(int i);
        return i == 0 ? 2 : (i == 1 ? 1 : 15);
    endfunction

    // Requesters must hold req and fields stable until granted
    logic        pq0[NI], pq1[NI];
    logic [64:0] fq0[NI], fq1[NI];
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst && pq0[i])
                assert (r0[i] && {w0[i], a0[i], d0[i]} == fq0[i])
                else $error("protocol violation m0 inst %0d", i);
            if (!rst && pq1[i])
                assert (r1[i] && {w1[i], a1[i], d1[i]} == fq1[i])
                else $error("protocol violation m1 inst %0d", i);
            pq0[i] <= !rst && r0[i] && !g0[i];
            pq1[i] <= !rst && r1[i] && !g1[i];
            fq0[i] <= {w0[i], a0[i], d0[i]};
            fq1[i] <= {w1[i], a1[i], d1[i]};
        end
    end

    function automatic ob_t sample(int i);
        ob_t o;
        o.g0   = g0[i];
        o.g1   = g1[i];
        o.v0   = v0[i];
        o.v1   = v1[i];
        o.en   = en[i];
        o.we   = we[i];
        o.addr = ad[i];
        o.wd   = wd[i];
        o.rd0  = rd0[i];
        o.rd1  = rd1[i];
        return o;
    endfunction

    task automatic chk(string nm, int i, ob_t e);
        ob_t a;
        a = sample(i);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s inst=%0d k=%0d got=%h want=%h", nm, i, k, a, e);
        end
    endtask

    task automatic setin(int i, logic rr0, logic ww0, logic [31:0] aa0,
                         logic [31:0] dd0, logic rr1, logic ww1,
                         logic [31:0] aa1, logic [31:0] dd1, logic [31:0] mm);
        r0[i] = rr0; w0[i] = ww0; a0[i] = aa0; d0[i] = dd0;
        r1[i] = rr1; w1[i] = ww1; a1[i] = aa1; d1[i] = dd1;
        mrd[i] = mm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(
        logic rr0, logic ww0, logic [31:0] aa0, logic [31:0] dd0,
        logic rr1, logic ww1, logic [31:0] aa1, logic [31:0] dd1,
        logic [31:0] mm, logic eg0, logic eg1, logic ev0, logic ev1,
        logic een, logic ewe, logic [31:0] ead, logic [31:0] ewd,
        logic [31:0] er0, logic [31:0] er1);
        vec_t v;
        v.r0 = rr0; v.w0 = ww0; v.a0 = aa0; v.d0 = dd0;
        v.r1 = rr1; v.w1 = ww1; v.a1 = aa1; v.d1 = dd1;
        v.mrd = mm;
        v.exp.g0 = eg0; v.exp.g1 = eg1; v.exp.v0 = ev0; v.exp.v1 = ev1;
        v.exp.en = een; v.exp.we = ewe; v.exp.addr = ead; v.exp.wd = ewd;
        v.exp.rd0 = er0; v.exp.rd1 = er1;
        return v;
    endfunction

    // Transaction-level reference: each arbitration books the port for a
    // fixed number of cycles; outputs follow from the booked issue cycle.
    int          free_c[NI], g_c[NI];
    logic        last[NI], g_p[NI], g_we[NI], gq0[NI], gq1[NI];
    logic [31:0] g_a[NI], g_d[NI];
    logic [31:0] mem[NI][16];
    logic [31:0] erd[NI][2];

    task automatic rq_new(int i, int p, int mode);
        logic r, w;
        logic [31:0] a, d;
        r = (mode != 0) || ($urandom_range(0, 2) == 0);
        w = (mode == 2) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        a = $urandom & 32'hFFFF_FFFC;
        d = $urandom;
        if (p == 0) begin
            r0[i] = r; w0[i] = w; a0[i] = a; d0[i] = d;
        end else begin
            r1[i] = r; w1[i] = w; a1[i] = a; d1[i] = d;
        end
    endtask

    task automatic rnd_cycle(int mode);
        ob_t  e;
        logic isu, rv, cap, win;
        for (int i = 0; i < NI; i++) begin
            cap = g_c[i] >= 0 && !g_we[i] && k == g_c[i] + lat(i);
            mrd[i] = cap ? mem[i][g_a[i][5:2]] : $urandom;
        end
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            isu = (k == g_c[i]);
            rv  = g_c[i] >= 0 && !g_we[i] && k == g_c[i] + lat(i) + 1;
            cap = g_c[i] >= 0 && !g_we[i] && k == g_c[i] + lat(i);
            e.g0   = isu && !g_p[i];
            e.g1   = isu && g_p[i];
            e.en   = isu;
            e.we   = isu && g_we[i];
            e.addr = isu ? g_a[i] : 32'h0;
            e.wd   = isu ? g_d[i] : 32'h0;
            e.v0   = rv && !g_p[i];
            e.v1   = rv && g_p[i];
            e.rd0  = erd[i][0];
            e.rd1  = erd[i][1];
            chk("rand", i, e);
            gq0[i] = isu && !g_p[i];
            gq1[i] = isu && g_p[i];
            if (isu && g_we[i]) mem[i][g_a[i][5:2]] = g_d[i];
            if (cap) erd[i][g_p[i]] = mem[i][g_a[i][5:2]];
            if (k >= free_c[i] && (r0[i] || r1[i])) begin
                win       = (r0[i] && r1[i]) ? !last[i] : r1[i];
                g_c[i]    = k + 1;
                g_p[i]    = win;
                g_we[i]   = win ? w1[i] : w0[i];
                g_a[i]    = win ? a1[i] : a0[i];
                g_d[i]    = win ? d1[i] : d0[i];
                last[i]   = win;
                free_c[i] = k + (g_we[i] ? 2 : lat(i) + 3);
            end
        end
        tick();
        for (int i = 0; i < NI; i++) begin
            if (gq0[i] || !r0[i]) rq_new(i, 0, mode);
            if (gq1[i] || !r1[i]) rq_new(i, 1, mode);
        end
        k++;
    endtask

    localparam logic [31:0] D = 32'hDEADBEEF;
    localparam logic [31:0] C = 32'hCAFEF00D;
    localparam logic [31:0] B = 32'h0BADF00D;
    localparam logic [31:0] Q = 32'h12345678;

    initial begin
        vec_t tv[$];
        ob_t  e;

        tv.push_back(mk(1,0,'h40,0, 0,0,0,0, 0,           0,0,0,0,0,0, 0,0, 0,0));
        tv.push_back(mk(1,0,'h40,0, 0,0,0,0, 0,           1,0,0,0,1,0, 'h40,0, 0,0));
        tv.push_back(mk(0,0,0,0,    0,0,0,0, 'h11111111,  0,0,0,0,0,0, 0,0, 0,0));
        tv.push_back(mk(0,0,0,0,    0,0,0,0, D,           0,0,0,0,0,0, 0,0, 0,0));
        tv.push_back(mk(0,0,0,0,    0,0,0,0, 'h22222222,  0,0,1,0,0,0, 0,0, D,0));
        tv.push_back(mk(0,0,0,0,    1,1,'h80,'h1234, 'h33333333, 0,0,0,0,0,0, 0,0, D,0));
        tv.push_back(mk(0,0,0,0,    1,1,'h80,'h1234, 0,   0,1,0,0,1,1, 'h80,'h1234, D,0));
        tv.push_back(mk(1,0,'h44,'h5555, 0,0,0,0, 0,      0,0,0,0,0,0, 0,0, D,0));
        tv.push_back(mk(1,0,'h44,'h5555, 0,0,0,0, 0,      1,0,0,0,1,0, 'h44,'h5555, D,0));
        tv.push_back(mk(0,0,0,0,    0,0,0,0, 'h44444444,  0,0,0,0,0,0, 0,0, D,0));
        tv.push_back(mk(0,0,0,0,    0,0,0,0, C,           0,0,0,0,0,0, 0,0, D,0));
        tv.push_back(mk(0,0,0,0,    0,0,0,0, 'h55555555,  0,0,1,0,0,0, 0,0, C,0));
        tv.push_back(mk(1,0,'h48,0, 1,0,'h4C,0, 0,        0,0,0,0,0,0, 0,0, C,0));
        tv.push_back(mk(1,0,'h48,0, 1,0,'h4C,0, 0,        0,1,0,0,1,0, 'h4C,0, C,0));
        tv.push_back(mk(1,0,'h48,0, 0,0,0,0, 'h66666666,  0,0,0,0,0,0, 0,0, C,0));
        tv.push_back(mk(1,0,'h48,0, 0,0,0,0, B,           0,0,0,0,0,0, 0,0, C,0));
        tv.push_back(mk(1,0,'h48,0, 0,0,0,0, 'h77777777,  0,0,0,1,0,0, 0,0, C,B));
        tv.push_back(mk(1,0,'h48,0, 0,0,0,0, 0,           0,0,0,0,0,0, 0,0, C,B));
        tv.push_back(mk(1,0,'h48,0, 0,0,0,0, 0,           1,0,0,0,1,0, 'h48,0, C,B));
        tv.push_back(mk(0,0,0,0,    0,0,0,0, 'h88888888,  0,0,0,0,0,0, 0,0, C,B));
        tv.push_back(mk(0,0,0,0,    0,0,0,0, Q,           0,0,0,0,0,0, 0,0, C,B));
        tv.push_back(mk(0,0,0,0,    0,0,0,0, 0,           0,0,1,0,0,0, 0,0, Q,B));

        for (int i = 0; i < NI; i++) setin(i, 0,0,0,0, 0,0,0,0, 0);

        // Reset, then a quiet period with no requests
        rst = 1'b1;
        repeat (3) begin
            tick();
            @(negedge clk);
            for (int i = 0; i < NI; i++) chk("reset", i, '0);
        end
        tick();
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) chk("quiet", i, '0);
            tick();
        end

        // Directed vectors on the MEM_LAT=2 instance
        for (int j = 0; j < tv.size(); j++) begin
            setin(0, tv[j].r0, tv[j].w0, tv[j].a0, tv[j].d0,
                  tv[j].r1, tv[j].w1, tv[j].a1, tv[j].d1, tv[j].mrd);
            k = j;
            @(negedge clk);
            chk("vec", 0, tv[j].exp);
            tick();
        end

        // Reset while a read is waiting on memory
        setin(0, 1,0,'h50,0, 0,0,0,0, 'h99999999);
        e = '0; e.rd0 = Q; e.rd1 = B;
        @(negedge clk);
        chk("rst_mid_req", 0, e);
        tick();
        e.g0 = 1'b1; e.en = 1'b1; e.addr = 'h50;
        @(negedge clk);
        chk("rst_mid_gnt", 0, e);
        tick();
        r0[0] = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("rst_mid_quiet", 0, '0);
            tick();
        end
        setin(0, 1,0,'h54,0, 0,0,0,0, 0);
        @(negedge clk);
        chk("rst_mid_idle", 0, '0);
        tick();
        e = '0; e.g0 = 1'b1; e.en = 1'b1; e.addr = 'h54;
        @(negedge clk);
        chk("rst_mid_regnt", 0, e);
        tick();
        r0[0] = 1'b0;

        // Randomized traffic on all three latencies
        for (int i = 0; i < NI; i++) setin(i, 0,0,0,0, 0,0,0,0, 0);
        rst = 1'b1;
        tick();
        tick();
        for (int i = 0; i < NI; i++) begin
            free_c[i] = 0;
            g_c[i]    = -1;
            last[i]   = 1'b1;
            g_p[i]    = 1'b0;
            g_we[i]   = 1'b0;
            g_a[i]    = '0;
            g_d[i]    = '0;
            erd[i][0] = '0;
            erd[i][1] = '0;
            for (int m = 0; m < 16; m++) mem[i][m] = $urandom;
            rq_new(i, 0, 1);
            rq_new(i, 1, 1);
        end
        rst = 1'b0;
        k = 0;
        repeat (80) rnd_cycle(1);
        repeat (40) rnd_cycle(2);
        repeat (2500) rnd_cycle(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter for the single unified instruction/data memory port of the multicycle RISC-V core. Port 0 serves the core's fetch/load/store path and port 1 serves the program loader or debug agent. Only one memory transaction is in flight at a time. Round-robin arbitration with per-port grant and read-valid handshakes lets the loader fill memory while the core is stalled, without a second memory port.

## Interface
Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, memory read latency in cycles, counted from the cycle `mem_en` is high to the cycle `mem_rdata` is valid; legal values are 1..15.

Ports (N = 0, 1):
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mN_req  in  1  request; held high until `mN_gnt`.
- mN_we  in  1  1 = write, 0 = read; held stable with `mN_req`.
- mN_addr  in  ADDR_W  address; held stable with `mN_req`.
- mN_wdata  in  DATA_W  write data; held stable with `mN_req`.
- mN_gnt  out  1  one-cycle pulse; the request is issued to memory in this cycle.
- mN_rdata  out  DATA_W  read data register; valid while `mN_rvalid` is high.
- mN_rvalid  out  1  one-cycle pulse marking read completion.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable, qualified by `mem_en`.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after `mem_en`.

## Operation
The FSM has four states: IDLE, ISSUE, WAIT and DONE.

- **IDLE.** If any `mN_req` is high, select a winner, register it in `sel`, and go to ISSUE. Otherwise stay in IDLE.
  - Round-robin: when both ports request, the port not granted last wins.
  - The last-grant pointer resets to 1, so port 0 wins the first tie.
  - When only one port requests, it wins regardless of the pointer.
- **ISSUE.** Assert `mem_en` and `m[sel]_gnt`. Drive `mem_we`, `mem_addr` and `mem_wdata` combinationally from the `sel` port's inputs. Update the last-grant pointer to `sel`.
  - Write: go to IDLE.
  - Read: load the wait counter with MEM_LAT-1 and go to WAIT.
- **WAIT.** While the counter is non-zero, decrement it. When it is zero, capture `mem_rdata` into `m[sel]_rdata` and go to DONE. `mem_rdata` is sampled in exactly the cycle ISSUE+MEM_LAT.
- **DONE.** Assert `m[sel]_rvalid` and go to IDLE.
- **Inactive outputs.** Outside ISSUE, `mem_en`, `mem_we`, `mem_addr` and `mem_wdata` are driven to 0. Each port's `mN_rdata` holds its last captured value. The other port's `rdata` is never modified.
- **Ignored inputs.** Requests arriving in ISSUE, WAIT or DONE are not evaluated. Requesters keep `req` high, and the request is arbitrated in the next IDLE.
- **Protocol violations.** Dropping `req`, or changing `we`/`addr`/`wdata`, before `gnt` is a protocol violation. The arbiter does not re-check `req` in ISSUE. The bench flags a violation with an assertion.
- **Reset.** When `rst` is high at an edge, the FSM goes to IDLE, the pointer to 1, the counter to 0, and both `rdata` registers to 0. Any in-flight read is dropped and no `rvalid` is produced for it. Reset has priority over every transition.

## Timing
Reset values: all outputs are 0 (`gnt`, `rvalid`, `rdata`, `mem_*`).

Request seen in IDLE at cycle t:
- Issue cycle: t+1 (`gnt` and `mem_en` high).
- Read capture: t+1+MEM_LAT.
- `rvalid`: t+2+MEM_LAT.
- Next arbitration: t+3+MEM_LAT.
- Write: back in IDLE at t+2. Write throughput is one write per 2 cycles.

Other timing rules:
- Read throughput is one read per MEM_LAT+3 cycles.
- Continuous requests from both ports alternate 0,1,0,1 starting with 0 after reset.
- `gnt` and `rvalid` are never high on both ports in the same cycle. At most one of the four pulses is high in any cycle.
- A port may re-raise `req`, or hold it high, in the cycle after its `rvalid` or `gnt`. It is arbitrated in that IDLE cycle.

## Test plan
- **Reset.** Apply reset, then release it with no requests → all outputs 0 and `mem_en` never high for 20 cycles. Assert `rst` during WAIT of a read → no `rvalid`, `rdata` = 0, FSM in IDLE.
- **Single read, MEM_LAT=2.** m0 reads 0x40 at t, memory returns 0xDEADBEEF at t+3 → `m0_gnt` and `mem_en` at t+1 with `mem_addr`=0x40, `mem_we`=0; `m0_rvalid` at t+4 with `m0_rdata`=0xDEADBEEF; `m1_rdata` unchanged.
- **Single write.** m1 writes 0x1234 to 0x80 at t → `m1_gnt`, `mem_en`, `mem_we` at t+1 with `mem_addr`=0x80 and `mem_wdata`=0x1234; no `rvalid`; IDLE at t+2.
- **Contention.** Both ports hold reads from reset → grants go 0,1,0,1. Each `rvalid` goes to the matching port with its own data. There is never a double grant.
- **Writes to both ports.** m0 writes while m1 keeps requesting writes → grants alternate every 2 cycles, and m1 waits at most one transaction.
- **Parameter sweep.** MEM_LAT=1 and MEM_LAT=15 → `rvalid` exactly MEM_LAT+2 cycles after the request; `mem_rdata` is sampled only in the capture cycle, so a bench that drives garbage in other cycles sees the correct value returned.
